// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states and default bus widths
// (the widths are also used by the APB RAM slave).
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command, response and APB bus signals of the APB requester, bundled with
// a requester-side (master) and an environment-side (slave) view.
interface apb_master_ctrl_if #(
    parameter int ADDR_W = apb_pkg::APB_ADDR_W,
    parameter int DATA_W = apb_pkg::APB_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_master_ctrl.sv
// APB requester: sequences one read/write command at a time through SETUP and
// ACCESS, returning data/error on a valid/ready response port with a timeout.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    apb_master_ctrl_if.master bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb_mst_state_t   state;
    apb_mst_state_t   state_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic             timeout_hit;

    assign timeout_hit   = (TIMEOUT_CYCLES > 0) && (to_cnt == TO_LAST);
    assign bus.cmd_ready = (state == IDLE);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.pready || timeout_hit) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus and response registers; pready/pslverr only matter in ACCESS.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pwrite      <= 1'b0;
            bus.paddr       <= '0;
            bus.pwdata      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            to_cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.psel    <= 1'b1;
                        bus.penable <= 1'b0;
                        bus.pwrite  <= bus.cmd_write;
                        bus.paddr   <= bus.cmd_addr;
                        bus.pwdata  <= bus.cmd_write ? bus.cmd_wdata : '0;
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    to_cnt      <= '0;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
                        bus.rsp_err     <= bus.pslverr;
                        bus.rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a small 32-word APB RAM model;
// addresses >= 32 answer with pslverr, and pready can be forced low (hang).
module tb_apb_master_ctrl;

    logic pclk;
    logic presetn;
    logic hang;
    logic [31:0] mem [0:31];

    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // RAM slave: zero wait states unless hang is set
    assign bus.pready  = !hang;
    assign bus.prdata  = (bus.paddr < 32) ? mem[bus.paddr[4:0]] : 32'h0;
    assign bus.pslverr = bus.psel && bus.penable && (bus.paddr >= 32);

    always_ff @(posedge pclk) begin
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && (bus.paddr < 32))
            mem[bus.paddr[4:0]] <= bus.pwdata;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        logic        hang;
        int          lat;
        int          stall;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int n;
        logic [31:0] r_rdata;
        string p;
        p = $sformatf("v%0d", id);
        hang          = v.hang;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        n = 1;
        chk({p, "_setup_sel_en"}, {30'd0, bus.psel, bus.penable}, 32'd2);
        chk({p, "_setup_paddr"}, bus.paddr, v.addr);
        chk({p, "_setup_pwdata"}, bus.pwdata, v.wr ? v.wdata : 32'h0);
        chk({p, "_setup_pwrite"}, {31'd0, bus.pwrite}, {31'd0, v.wr});
        @(posedge pclk); #1;
        n = 2;
        chk({p, "_access_sel_en"}, {30'd0, bus.psel, bus.penable}, 32'd3);
        chk({p, "_access_paddr"}, bus.paddr, v.addr);
        while (!bus.rsp_valid && n < 100) begin
            @(posedge pclk); #1;
            n++;
        end
        hang = 1'b0;
        chk({p, "_latency"}, n, v.lat);
        chk({p, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
        chk({p, "_err"}, {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
        chk({p, "_timeout"}, {31'd0, bus.rsp_timeout}, {31'd0, v.exp_to});
        chk({p, "_resp_psel_cmdrdy"}, {30'd0, bus.psel, bus.cmd_ready}, 32'd0);
        r_rdata = bus.rsp_rdata;
        for (int s = 0; s < v.stall; s++) begin
            @(posedge pclk); #1;
            chk({p, $sformatf("_stall%0d", s)},
                {26'd0, bus.rsp_valid, bus.rsp_rdata == r_rdata, bus.rsp_err, bus.rsp_timeout,
                 bus.cmd_ready, bus.psel},
                {26'd0, 1'b1, 1'b1, v.exp_err, v.exp_to, 1'b0, 1'b0});
        end
        bus.rsp_ready = 1'b1;
        @(posedge pclk); #1;
        bus.rsp_ready = 1'b0;
        chk({p, "_release"}, {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
    endtask

    vec_t vecs [12];
    vec_t rb;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];

    initial begin
        int idx, rises, rsp_cnt, stable_bad, rsp_err_bad, seen_bad;
        logic acc, hs, hs_err, prev_psel;
        logic [31:0] cur_addr;

        //            wr    addr    wdata          exp_rdata      err   to    hang  lat stall
        vecs[0]  = '{1'b1, 32'd5,  32'hDEADBEEF, 32'h0,         1'b0, 1'b0, 1'b0, 3,  0};
        vecs[1]  = '{1'b0, 32'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 3,  0};
        vecs[2]  = '{1'b0, 32'd40, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 3,  0};
        vecs[3]  = '{1'b1, 32'd40, 32'h11111111, 32'h0,         1'b1, 1'b0, 1'b0, 3,  0};
        vecs[4]  = '{1'b1, 32'd3,  32'h12345678, 32'h0,         1'b0, 1'b0, 1'b0, 3,  0};
        vecs[5]  = '{1'b0, 32'd3,  32'h0,        32'h0,         1'b1, 1'b1, 1'b1, 18, 3};
        vecs[6]  = '{1'b0, 32'd3,  32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 3,  5};
        vecs[7]  = '{1'b1, 32'd31, 32'hA5A5A5A5, 32'h0,         1'b0, 1'b0, 1'b0, 3,  0};
        vecs[8]  = '{1'b0, 32'd31, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 3,  0};
        vecs[9]  = '{1'b0, 32'd32, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 3,  0};
        vecs[10] = '{1'b1, 32'd3,  32'hCAFEF00D, 32'h0,         1'b1, 1'b1, 1'b1, 18, 2};
        vecs[11] = '{1'b0, 32'd3,  32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 3,  0};

        b2b_addr[0] = 32'd10; b2b_data[0] = 32'h0000A001;
        b2b_addr[1] = 32'd11; b2b_data[1] = 32'h0000B002;
        b2b_addr[2] = 32'd12; b2b_data[2] = 32'h0000C003;

        hang          = 1'b0;
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_apb", {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd0);
        chk("reset_paddr", bus.paddr, 32'h0);
        chk("reset_rsp", {28'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.cmd_ready}, 32'd1);
        chk("reset_rdata", bus.rsp_rdata, 32'h0);
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of a hung ACCESS phase
        hang          = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd3;
        bus.cmd_valid = 1'b1;
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #3;
        chk("rst_pre_in_access", {30'd0, bus.psel, bus.penable}, 32'd3);
        presetn = 1'b0;
        #1;
        chk("rst_async_outputs", {29'd0, bus.psel, bus.penable, bus.rsp_valid}, 32'd0);
        hang = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;
        chk("rst_cmd_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
        seen_bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge pclk); #1;
            if (bus.rsp_valid || bus.psel) seen_bad++;
        end
        chk("rst_no_response", seen_bad, 0);

        // Three writes queued with cmd_valid held high
        idx = 0; rises = 0; rsp_cnt = 0; stable_bad = 0; rsp_err_bad = 0;
        prev_psel = 1'b0; cur_addr = '0;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = b2b_addr[0];
        bus.cmd_wdata = b2b_data[0];
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 60 && rsp_cnt < 3; c++) begin
            @(negedge pclk);
            acc    = bus.cmd_valid && bus.cmd_ready;
            hs     = bus.rsp_valid && bus.rsp_ready;
            hs_err = bus.rsp_err || bus.rsp_timeout;
            @(posedge pclk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    bus.cmd_addr  = b2b_addr[idx];
                    bus.cmd_wdata = b2b_data[idx];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            if (hs) begin
                rsp_cnt++;
                if (hs_err) rsp_err_bad++;
            end
            if (bus.psel && !prev_psel) begin
                cur_addr = bus.paddr;
                if (rises < 3) chk($sformatf("b2b_paddr%0d", rises), cur_addr, b2b_addr[rises]);
                rises++;
            end
            if (bus.psel && bus.paddr != cur_addr) stable_bad++;
            prev_psel = bus.psel;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("b2b_responses", rsp_cnt, 3);
        chk("b2b_psel_rises", rises, 3);
        chk("b2b_paddr_stable", stable_bad, 0);
        chk("b2b_rsp_err", rsp_err_bad, 0);
        @(posedge pclk); #1;

        for (int i = 0; i < 3; i++) begin
            rb = '{1'b0, b2b_addr[i], 32'h0, b2b_data[i], 1'b0, 1'b0, 1'b0, 3, 0};
            run_vec(rb, 20 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
